// File: rtl/softex_tcdm_lockstep_splitter.sv
// Splits one wide TCDM request into MP 32-bit ports with per-port grant tracking
// and per-port response FIFOs that re-align skewed narrow responses.
module softex_tcdm_lockstep_splitter_fifo #(
  parameter int unsigned W     = 32,
  parameter int unsigned DEPTH = 3
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clear_i,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] data_o,
  output logic         empty_o
);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0][W-1:0] mem_q;
  logic [PW-1:0]           wr_q, rd_q;
  logic [CW-1:0]           cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (clear_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= (wr_q == PW'(DEPTH - 1)) ? '0 : wr_q + 1'b1;
      end
      if (pop_i)
        rd_q <= (rd_q == PW'(DEPTH - 1)) ? '0 : rd_q + 1'b1;
      cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
    end
  end

  assign data_o  = mem_q[rd_q];
  assign empty_o = (cnt_q == '0);
endmodule

module softex_tcdm_lockstep_splitter #(
  parameter int unsigned DW         = 128,
  parameter int unsigned MP         = DW / 32,
  parameter int unsigned RESP_DEPTH = 3,
  parameter int unsigned ID_WIDTH   = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         clear_i,
  output logic                         busy_o,
  input  logic                         in_req_i,
  output logic                         in_gnt_o,
  input  logic [31:0]                  in_add_i,
  input  logic                         in_wen_i,
  input  logic [DW/8-1:0]              in_be_i,
  input  logic [DW-1:0]                in_data_i,
  input  logic [ID_WIDTH-1:0]          in_id_i,
  output logic                         in_r_valid_o,
  input  logic                         in_r_ready_i,
  output logic [DW-1:0]                in_r_data_o,
  output logic [ID_WIDTH-1:0]          in_r_id_o,
  output logic [MP-1:0]                tcdm_req_o,
  input  logic [MP-1:0]                tcdm_gnt_i,
  output logic [MP-1:0][31:0]          tcdm_add_o,
  output logic [MP-1:0]                tcdm_wen_o,
  output logic [MP-1:0][3:0]           tcdm_be_o,
  output logic [MP-1:0][31:0]          tcdm_data_o,
  output logic [MP-1:0][ID_WIDTH-1:0]  tcdm_id_o,
  input  logic [MP-1:0]                tcdm_r_valid_i,
  input  logic [MP-1:0][31:0]          tcdm_r_data_i,
  output logic [MP-1:0]                tcdm_r_ready_o
);
  localparam int unsigned CW = $clog2(RESP_DEPTH + 1);

  logic [MP-1:0]       done_q, done_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                can_issue, pop;
  logic [MP-1:0]       fifo_empty;
  logic [MP-1:0][31:0] fifo_head;
  logic                id_empty;

  // Issue is gated only on cnt_q; it cannot grow while a wide request is
  // partially granted, so a started transaction always completes.
  assign can_issue = (cnt_q < CW'(RESP_DEPTH));
  assign in_gnt_o  = in_req_i & can_issue & (&(done_q | tcdm_gnt_i));
  assign pop       = in_r_valid_o & in_r_ready_i;

  for (genvar i = 0; i < MP; i++) begin : g_port
    assign tcdm_req_o[i]  = in_req_i & can_issue & ~done_q[i];
    assign tcdm_add_o[i]  = in_add_i + 32'(4 * i);
    assign tcdm_wen_o[i]  = in_wen_i;
    assign tcdm_be_o[i]   = in_be_i[i*4 +: 4];
    assign tcdm_data_o[i] = in_data_i[i*32 +: 32];
    assign tcdm_id_o[i]   = in_id_i;

    softex_tcdm_lockstep_splitter_fifo #(.W(32), .DEPTH(RESP_DEPTH)) i_rfifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .clear_i (clear_i),
      .push_i  (tcdm_r_valid_i[i]),
      .data_i  (tcdm_r_data_i[i]),
      .pop_i   (pop),
      .data_o  (fifo_head[i]),
      .empty_o (fifo_empty[i])
    );
  end

  softex_tcdm_lockstep_splitter_fifo #(.W(ID_WIDTH), .DEPTH(RESP_DEPTH)) i_idfifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (clear_i),
    .push_i  (in_gnt_o),
    .data_i  (in_id_i),
    .pop_i   (pop),
    .data_o  (in_r_id_o),
    .empty_o (id_empty)
  );

  assign in_r_valid_o   = ~(|fifo_empty) & ~id_empty;
  assign in_r_data_o    = fifo_head;
  assign tcdm_r_ready_o = '1;
  assign busy_o         = (cnt_q != '0) | (done_q != '0);

  always_comb begin
    done_d = done_q | (tcdm_req_o & tcdm_gnt_i);
    if (in_gnt_o) done_d = '0;
    cnt_d = cnt_q + CW'(in_gnt_o) - CW'(pop);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      done_q <= '0;
      cnt_q  <= '0;
    end else if (clear_i) begin
      done_q <= '0;
      cnt_q  <= '0;
    end else begin
      done_q <= done_d;
      cnt_q  <= cnt_d;
    end
  end
endmodule

// File: tb/tb_softex_tcdm_lockstep_splitter.sv
// Directed bench for softex_tcdm_lockstep_splitter (DW=128, MP=4, RESP_DEPTH=3).
module tb_softex_tcdm_lockstep_splitter;
  logic              clk_i = 1'b0;
  logic              rst_ni, clear_i, busy_o;
  logic              in_req_i, in_gnt_o, in_wen_i;
  logic [31:0]       in_add_i;
  logic [15:0]       in_be_i;
  logic [127:0]      in_data_i, in_r_data_o;
  logic [7:0]        in_id_i, in_r_id_o;
  logic              in_r_valid_o, in_r_ready_i;
  logic [3:0]        tcdm_req_o, tcdm_gnt_i, tcdm_wen_o, tcdm_r_valid_i, tcdm_r_ready_o;
  logic [3:0][31:0]  tcdm_add_o, tcdm_data_o, tcdm_r_data_i;
  logic [3:0][3:0]   tcdm_be_o;
  logic [3:0][7:0]   tcdm_id_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  softex_tcdm_lockstep_splitter dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i), .busy_o(busy_o),
    .in_req_i(in_req_i), .in_gnt_o(in_gnt_o), .in_add_i(in_add_i), .in_wen_i(in_wen_i),
    .in_be_i(in_be_i), .in_data_i(in_data_i), .in_id_i(in_id_i),
    .in_r_valid_o(in_r_valid_o), .in_r_ready_i(in_r_ready_i),
    .in_r_data_o(in_r_data_o), .in_r_id_o(in_r_id_o),
    .tcdm_req_o(tcdm_req_o), .tcdm_gnt_i(tcdm_gnt_i), .tcdm_add_o(tcdm_add_o),
    .tcdm_wen_o(tcdm_wen_o), .tcdm_be_o(tcdm_be_o), .tcdm_data_o(tcdm_data_o),
    .tcdm_id_o(tcdm_id_o), .tcdm_r_valid_i(tcdm_r_valid_i),
    .tcdm_r_data_i(tcdm_r_data_i), .tcdm_r_ready_o(tcdm_r_ready_o)
  );

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // 1-cycle TCDM responder: a port granted in cycle t answers in t+1 with {id, port}.
  logic [3:0] pend = '0;
  logic [7:0] pend_id = '0;
  int         ngr = 0;

  task automatic drv_model();
    tcdm_r_valid_i = pend;
    for (int p = 0; p < 4; p++) tcdm_r_data_i[p] = {pend_id, 24'(p)};
  endtask

  task automatic adv();
    pend    = tcdm_req_o & tcdm_gnt_i;
    pend_id = in_id_i;
    if (in_gnt_o) ngr++;
    @(posedge clk_i); #1;
  endtask

  function automatic logic [127:0] mdata(input logic [7:0] id);
    return {id, 24'd3, id, 24'd2, id, 24'd1, id, 24'd0};
  endfunction

  typedef struct {
    logic         req;
    logic         wen;
    logic [31:0]  add;
    logic [15:0]  be;
    logic [127:0] data;
    logic [3:0]   gnt;
    logic [3:0]   e_req;
    logic         e_gnt;
    logic [127:0] e_add;
    logic [3:0]   e_wen;
  } vec_t;

  vec_t vecs[4];

  initial begin
    vecs[0] = '{1'b1, 1'b1, 32'h0000_1000, 16'hFFFF, {32'h4, 32'h3, 32'h2, 32'h1}, 4'h0,
                4'hF, 1'b0, {32'h100C, 32'h1008, 32'h1004, 32'h1000}, 4'hF};
    vecs[1] = '{1'b0, 1'b0, 32'hFFFF_FFF8, 16'h0000, 128'h0, 4'hF,
                4'h0, 1'b0, {32'h4, 32'h0, 32'hFFFF_FFFC, 32'hFFFF_FFF8}, 4'h0};
    vecs[2] = '{1'b1, 1'b0, 32'h0000_0020, 16'h8421, {32'hCAFE, 32'hBEEF, 32'h1234, 32'h5678}, 4'h0,
                4'hF, 1'b0, {32'h2C, 32'h28, 32'h24, 32'h20}, 4'h0};
    vecs[3] = '{1'b1, 1'b1, 32'h7FFF_FFFC, 16'h00F0, 128'h0, 4'h0,
                4'hF, 1'b0, {32'h8000_0008, 32'h8000_0004, 32'h8000_0000, 32'h7FFF_FFFC}, 4'hF};

    rst_ni = 1'b0; clear_i = 1'b0; in_req_i = 1'b0; in_add_i = '0; in_wen_i = 1'b0;
    in_be_i = '0; in_data_i = '0; in_id_i = '0; in_r_ready_i = 1'b0;
    tcdm_gnt_i = '0; tcdm_r_valid_i = '0; tcdm_r_data_i = '0;
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;

    // reset state
    @(negedge clk_i);
    chk("rst_busy", 128'(busy_o), 128'h0);
    chk("rst_rvalid", 128'(in_r_valid_o), 128'h0);
    chk("rst_rready", 128'(tcdm_r_ready_o), 128'hF);
    @(posedge clk_i); #1;

    // combinational slicing / gating table (no wide grant ever completes)
    for (int v = 0; v < 4; v++) begin
      in_req_i = vecs[v].req; in_wen_i = vecs[v].wen; in_add_i = vecs[v].add;
      in_be_i = vecs[v].be; in_data_i = vecs[v].data; tcdm_gnt_i = vecs[v].gnt;
      @(negedge clk_i);
      chk($sformatf("vec%0d_req", v), 128'(tcdm_req_o), 128'(vecs[v].e_req));
      chk($sformatf("vec%0d_gnt", v), 128'(in_gnt_o), 128'(vecs[v].e_gnt));
      chk($sformatf("vec%0d_add", v), tcdm_add_o, vecs[v].e_add);
      chk($sformatf("vec%0d_be", v), 128'(tcdm_be_o), 128'(vecs[v].be));
      chk($sformatf("vec%0d_data", v), tcdm_data_o, vecs[v].data);
      chk($sformatf("vec%0d_wen", v), 128'(tcdm_wen_o), 128'(vecs[v].e_wen));
      @(posedge clk_i); #1;
    end
    in_req_i = 1'b0; tcdm_gnt_i = '0;
    @(negedge clk_i);
    chk("vec_busy", 128'(busy_o), 128'h0);
    @(posedge clk_i); #1;

    // lockstep read
    in_req_i = 1'b1; in_wen_i = 1'b1; in_add_i = 32'h1000; in_id_i = 8'h5A; tcdm_gnt_i = 4'hF;
    in_be_i = 16'hFFFF;
    @(negedge clk_i);
    chk("ls_add", tcdm_add_o, {32'h100C, 32'h1008, 32'h1004, 32'h1000});
    chk("ls_id", 128'(tcdm_id_o), 128'h5A5A5A5A);
    chk("ls_gnt", 128'(in_gnt_o), 128'h1);
    @(posedge clk_i); #1;
    in_req_i = 1'b0; tcdm_gnt_i = '0; tcdm_r_valid_i = 4'hF;
    tcdm_r_data_i = {32'h44, 32'h33, 32'h22, 32'h11};
    @(negedge clk_i);
    chk("ls_nofall", 128'(in_r_valid_o), 128'h0);
    @(posedge clk_i); #1;
    tcdm_r_valid_i = '0; in_r_ready_i = 1'b1;
    @(negedge clk_i);
    chk("ls_rvalid", 128'(in_r_valid_o), 128'h1);
    chk("ls_rdata", in_r_data_o, {32'h44, 32'h33, 32'h22, 32'h11});
    chk("ls_rid", 128'(in_r_id_o), 128'h5A);
    @(posedge clk_i); #1;
    @(negedge clk_i);
    chk("ls_idle", 128'({busy_o, in_r_valid_o}), 128'h0);
    adv();

    // staggered grants with model responses
    in_req_i = 1'b1; in_id_i = 8'h33; tcdm_gnt_i = 4'b0100; drv_model();
    @(negedge clk_i);
    chk("st_c0_req", 128'(tcdm_req_o), 128'hF);
    chk("st_c0_gnt", 128'(in_gnt_o), 128'h0);
    adv();
    tcdm_gnt_i = 4'b0011; drv_model();
    @(negedge clk_i);
    chk("st_c1_req", 128'(tcdm_req_o), 128'b1011);
    chk("st_c1_gnt", 128'(in_gnt_o), 128'h0);
    adv();
    tcdm_gnt_i = 4'b0000; drv_model();
    @(negedge clk_i);
    chk("st_c2_req", 128'(tcdm_req_o), 128'b1000);
    chk("st_c2_busy", 128'(busy_o), 128'h1);
    chk("st_c2_rvalid", 128'(in_r_valid_o), 128'h0);
    adv();
    tcdm_gnt_i = 4'b1000; drv_model();
    @(negedge clk_i);
    chk("st_c3_req", 128'(tcdm_req_o), 128'b1000);
    chk("st_c3_gnt", 128'(in_gnt_o), 128'h1);
    adv();
    in_req_i = 1'b0; tcdm_gnt_i = '0; drv_model();
    @(negedge clk_i);
    chk("st_c4_req", 128'(tcdm_req_o), 128'h0);
    chk("st_c4_rvalid", 128'(in_r_valid_o), 128'h0);
    adv();
    drv_model();
    @(negedge clk_i);
    chk("st_rvalid", 128'(in_r_valid_o), 128'h1);
    chk("st_rdata", in_r_data_o, mdata(8'h33));
    chk("st_rid", 128'(in_r_id_o), 128'h33);
    adv();

    // skewed responses: port 3 four cycles late
    in_req_i = 1'b1; in_id_i = 8'h77; tcdm_gnt_i = 4'hF;
    @(posedge clk_i); #1;
    in_req_i = 1'b0; tcdm_gnt_i = '0; tcdm_r_valid_i = 4'b0111;
    tcdm_r_data_i = {32'h0, 32'hC2, 32'hB1, 32'hA0};
    @(posedge clk_i); #1;
    tcdm_r_valid_i = '0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i);
      chk($sformatf("sk_wait%0d", c), 128'(in_r_valid_o), 128'h0);
      @(posedge clk_i); #1;
    end
    tcdm_r_valid_i = 4'b1000; tcdm_r_data_i = {32'hD3, 32'h0, 32'h0, 32'h0};
    @(negedge clk_i);
    chk("sk_same", 128'(in_r_valid_o), 128'h0);
    @(posedge clk_i); #1;
    tcdm_r_valid_i = '0;
    @(negedge clk_i);
    chk("sk_rvalid", 128'(in_r_valid_o), 128'h1);
    chk("sk_rdata", in_r_data_o, {32'hD3, 32'hC2, 32'hB1, 32'hA0});
    chk("sk_rid", 128'(in_r_id_o), 128'h77);
    adv();

    // back-pressure: continuous stream, no ready
    in_r_ready_i = 1'b0; ngr = 0; in_id_i = 8'd0; in_req_i = 1'b1; tcdm_gnt_i = 4'hF; pend = '0;
    for (int c = 0; c < 8; c++) begin
      drv_model();
      @(negedge clk_i);
      adv();
      in_id_i = 8'(ngr);
    end
    chk("bp_grants", 128'(ngr), 128'd3);
    in_r_ready_i = 1'b1; drv_model();
    @(negedge clk_i);
    chk("bp_req_off", 128'(tcdm_req_o), 128'h0);
    chk("bp_nobypass", 128'(in_gnt_o), 128'h0);
    chk("bp_busy", 128'(busy_o), 128'h1);
    chk("bp_rid0", 128'(in_r_id_o), 128'h0);
    chk("bp_rdata0", in_r_data_o, mdata(8'd0));
    adv();
    in_id_i = 8'(ngr); drv_model();
    @(negedge clk_i);
    chk("bp_resume", 128'(in_gnt_o), 128'h1);
    chk("bp_rid1", 128'(in_r_id_o), 128'h1);
    adv();
    in_req_i = 1'b0; tcdm_gnt_i = '0; drv_model();
    @(negedge clk_i);
    chk("bp_rid2", 128'(in_r_id_o), 128'h2);
    chk("bp_rvalid2", 128'(in_r_valid_o), 128'h1);
    adv();
    drv_model();
    @(negedge clk_i);
    chk("bp_rid3", 128'(in_r_id_o), 128'h3);
    chk("bp_rdata3", in_r_data_o, mdata(8'd3));
    adv();
    drv_model();
    @(negedge clk_i);
    chk("bp_drained", 128'({busy_o, in_r_valid_o}), 128'h0);
    adv();

    // write slicing
    in_req_i = 1'b1; in_wen_i = 1'b0; in_id_i = 8'h99; in_be_i = 16'h0F0F;
    in_data_i = {32'hDDDD_DDDD, 32'hCCCC_CCCC, 32'hBBBB_BBBB, 32'hAAAA_AAAA};
    tcdm_gnt_i = 4'hF; drv_model();
    @(negedge clk_i);
    chk("wr_be", 128'(tcdm_be_o), 128'h0F0F);
    chk("wr_data", tcdm_data_o, {32'hDDDD_DDDD, 32'hCCCC_CCCC, 32'hBBBB_BBBB, 32'hAAAA_AAAA});
    chk("wr_wen", 128'(tcdm_wen_o), 128'h0);
    chk("wr_gnt", 128'(in_gnt_o), 128'h1);
    adv();
    in_req_i = 1'b0; tcdm_gnt_i = '0; drv_model();
    @(negedge clk_i);
    chk("wr_nofall", 128'(in_r_valid_o), 128'h0);
    adv();
    drv_model();
    @(negedge clk_i);
    chk("wr_resp", 128'({in_r_valid_o, in_r_id_o}), 128'h199);
    adv();
    drv_model();
    @(negedge clk_i);
    chk("wr_idle", 128'(busy_o), 128'h0);
    adv();

    // async reset with done_q=0101 and cnt_q=2
    in_r_ready_i = 1'b0; in_req_i = 1'b1; tcdm_gnt_i = 4'hF; in_id_i = 8'h1;
    @(posedge clk_i); #1;
    in_id_i = 8'h2;
    @(posedge clk_i); #1;
    in_id_i = 8'h3; tcdm_gnt_i = 4'b0101;
    @(posedge clk_i); #1;
    tcdm_gnt_i = '0;
    @(negedge clk_i);
    chk("rs_pre_req", 128'(tcdm_req_o), 128'b1010);
    chk("rs_pre_busy", 128'(busy_o), 128'h1);
    #2 rst_ni = 1'b0;
    #1;
    chk("rs_busy", 128'(busy_o), 128'h0);
    chk("rs_rvalid", 128'(in_r_valid_o), 128'h0);
    chk("rs_req_all", 128'(tcdm_req_o), 128'hF);
    in_req_i = 1'b0;
    @(posedge clk_i); #1;
    rst_ni = 1'b1; in_req_i = 1'b1;
    @(negedge clk_i);
    chk("rs_restart", 128'(tcdm_req_o), 128'hF);
    chk("rs_nogrant", 128'(in_gnt_o), 128'h0);
    @(posedge clk_i); #1;
    in_req_i = 1'b0;
    @(posedge clk_i); #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
